// File: rtl/button_event_detect.sv
// Multi-channel button front end: polarity fix, two-flop synchroniser, debounce
// and single-cycle press / release / long-press events per channel.
`timescale 1ns/1ps

module button_event_detect #(
  parameter int N_CH       = 4,
  parameter int DB_CNT     = 500000,
  parameter int LONG_CNT   = 100000000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] input_sig,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic            any_event
);

  localparam int CNT_W  = $clog2(DB_CNT);
  localparam int HOLD_W = $clog2(LONG_CNT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DB_CNT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  // Compared against the pre-increment value so long_pulse lands exactly
  // LONG_CNT edges after rise_pulse.
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CNT - 2);

  logic [N_CH-1:0] pol;

  logic [N_CH-1:0] s1_q, s1_d;
  logic [N_CH-1:0] s2_q, s2_d;
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic [N_CH-1:0] long_q, long_d;
  logic [N_CH-1:0] done_q, done_d;
  logic            any_q, any_d;

  logic [CNT_W-1:0]  cnt_q  [N_CH];
  logic [CNT_W-1:0]  cnt_d  [N_CH];
  logic [HOLD_W-1:0] hold_q [N_CH];
  logic [HOLD_W-1:0] hold_d [N_CH];

  assign pol = input_sig ^ {N_CH{ACTIVE_LOW}};

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the loop below can leave a signal unassigned and infer a latch.
    s1_d    = pol;
    s2_d    = s1_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    long_d  = '0;
    done_d  = done_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;

    for (int i = 0; i < N_CH; i++) begin
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = s2_q[i];
        cnt_d[i]   = '0;
        rise_d[i]  = s2_q[i];
        fall_d[i]  = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end

      // Hold timer restarts on release and during the rise_pulse cycle.
      if (!level_q[i] || rise_q[i]) begin
        hold_d[i] = '0;
        done_d[i] = 1'b0;
      end else if (!done_q[i]) begin
        hold_d[i] = hold_q[i] + HOLD_ONE;
        if (hold_q[i] == HOLD_FIRE) begin
          long_d[i] = 1'b1;
          done_d[i] = 1'b1;
        end
      end
    end

    any_d = |{rise_d, fall_d, long_d};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      long_q  <= '0;
      done_q  <= '0;
      any_q   <= 1'b0;
      // NOTE: the per-channel counter arrays are plain flops, not RAM, so
      // they are reset element by element like any other state.
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
      done_q  <= done_d;
      any_q   <= any_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  assign level_o    = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign long_pulse = long_q;
  assign any_event  = any_q;

endmodule

// File: tb/tb_button_event_detect.sv
// Bench for button_event_detect: directed scenarios plus random input traffic,
// two instances (active-high and active-low) against a sample-window model.
`timescale 1ns/1ps

module tb_button_event_detect;

  localparam int N_CH = 4;
  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N_CH-1:0] in_a, in_b;
  logic [N_CH-1:0] lvl_a, rise_a, fall_a, long_a;
  logic [N_CH-1:0] lvl_b, rise_b, fall_b, long_b;
  logic            any_a, any_b;

  button_event_detect #(.N_CH(N_CH), .DB_CNT(DB), .LONG_CNT(LONG), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .input_sig(in_a), .level_o(lvl_a), .rise_pulse(rise_a),
    .fall_pulse(fall_a), .long_pulse(long_a), .any_event(any_a)
  );

  button_event_detect #(.N_CH(N_CH), .DB_CNT(DB), .LONG_CNT(LONG), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .input_sig(in_b), .level_o(lvl_b), .rise_pulse(rise_b),
    .fall_pulse(fall_b), .long_pulse(long_b), .any_event(any_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: s2 stream per channel as a plain sample history.
  int              k;
  bit              hist   [2][N_CH][HMAX];
  bit              lvl_m  [2][N_CH];
  bit              rise_v [2][N_CH];
  int              rise_e [2][N_CH];
  logic [N_CH-1:0] exp_lvl [2];
  logic [N_CH-1:0] exp_rise[2];
  logic [N_CH-1:0] exp_fall[2];
  logic [N_CH-1:0] exp_long[2];
  logic            exp_any [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_bit(input int i, input int c);
    return (i == 0) ? (in_a[c] ^ 1'b0) : (in_b[c] ^ 1'b1);
  endfunction

  function automatic logic [N_CH-1:0] get_vec(input int i, input int kind);
    logic [N_CH-1:0] v;
    case (kind)
      0:       v = (i == 0) ? lvl_a  : lvl_b;
      1:       v = (i == 0) ? rise_a : rise_b;
      2:       v = (i == 0) ? fall_a : fall_b;
      3:       v = (i == 0) ? long_a : long_b;
      default: v = {{(N_CH-1){1'b0}}, ((i == 0) ? any_a : any_b)};
    endcase
    return v;
  endfunction

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        hist[i][c][0] = 1'b0;
        hist[i][c][1] = 1'b0;
        lvl_m[i][c]   = 1'b0;
        rise_v[i][c]  = 1'b0;
        rise_e[i][c]  = 0;
      end
      exp_lvl[i]  = '0;
      exp_rise[i] = '0;
      exp_fall[i] = '0;
      exp_long[i] = '0;
      exp_any[i]  = 1'b0;
    end
  endtask

  // Edge k: the debounced state flips when the last DB synchronised samples
  // all disagree with it; long press fires exactly LONG edges after a rise.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      exp_rise[i] = '0;
      exp_fall[i] = '0;
      exp_long[i] = '0;
      for (int c = 0; c < N_CH; c++) begin
        bit all_opp;
        hist[i][c][k+2] = in_bit(i, c);
        if (lvl_m[i][c] && rise_v[i][c] && (k == rise_e[i][c] + LONG))
          exp_long[i][c] = 1'b1;
        all_opp = (k >= DB - 1);
        for (int j = k - DB + 1; j <= k; j++)
          if (j >= 0 && hist[i][c][j] == lvl_m[i][c]) all_opp = 1'b0;
        if (all_opp) begin
          lvl_m[i][c] = ~lvl_m[i][c];
          if (lvl_m[i][c]) begin
            exp_rise[i][c] = 1'b1;
            rise_e[i][c]   = k;
            rise_v[i][c]   = 1'b1;
          end else begin
            exp_fall[i][c] = 1'b1;
            rise_v[i][c]   = 1'b0;
          end
        end
        exp_lvl[i][c] = lvl_m[i][c];
      end
      exp_any[i] = |{exp_rise[i], exp_fall[i], exp_long[i]};
    end
    k++;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("inst%0d_level", i), get_vec(i, 0), exp_lvl[i]);
      check($sformatf("inst%0d_rise", i),  get_vec(i, 1), exp_rise[i]);
      check($sformatf("inst%0d_fall", i),  get_vec(i, 2), exp_fall[i]);
      check($sformatf("inst%0d_long", i),  get_vec(i, 3), exp_long[i]);
      check($sformatf("inst%0d_any", i),   get_vec(i, 4), exp_any[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int t = 0; t < n; t++) tick();
  endtask

  task automatic wait_pulse(input int i, input int kind, input int ch, input int bound,
                            output int n, output logic [N_CH-1:0] vec, output logic anyv);
    logic [N_CH-1:0] v;
    logic [N_CH-1:0] a;
    n    = -1;
    vec  = '0;
    anyv = 1'b0;
    for (int t = 1; t <= bound; t++) begin
      tick();
      v = get_vec(i, kind);
      if (v[ch]) begin
        a    = get_vec(i, 4);
        n    = t;
        vec  = v;
        anyv = a[0];
        break;
      end
    end
  endtask

  task automatic count_pulses(input int i, input int kind, input int ch, input int n, output int cnt);
    logic [N_CH-1:0] v;
    cnt = 0;
    for (int t = 0; t < n; t++) begin
      tick();
      v = get_vec(i, kind);
      if (v[ch]) cnt++;
    end
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    check("async_rst_outputs_hi", {lvl_a, rise_a, fall_a, long_a, 3'b0, any_a}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int              n, cnt, r;
    logic [N_CH-1:0] vec;
    logic            anyv;
    logic [N_CH-1:0] v;
    bit              bounce [5];

    rst  = 1'b0;
    in_a = '0;
    in_b = '1;
    model_reset();
    ticks(2);
    rst = 1'b1;
    ticks(3);

    // Reset: press held through an async reset is re-detected from scratch.
    in_a[0] = 1'b1;
    wait_pulse(0, 1, 0, 20, n, vec, anyv);
    check("press_latency_ch0", n, 6);
    ticks(3);
    async_reset();
    ticks(2);
    rst = 1'b1;
    wait_pulse(0, 1, 0, 20, n, vec, anyv);
    check("rst_release_rise_ch0", n, 6);
    in_a[0] = 1'b0;
    wait_pulse(0, 2, 0, 20, n, vec, anyv);
    check("release_fall_ch0", n, 6);
    ticks(3);

    // Clean press/release on ch1.
    in_a[1] = 1'b1;
    wait_pulse(0, 1, 1, 20, n, vec, anyv);
    check("clean_rise_ch1", n, 6);
    check("clean_rise_any", anyv, 1);
    ticks(2);
    in_a[1] = 1'b0;
    wait_pulse(0, 2, 1, 20, n, vec, anyv);
    check("clean_fall_ch1", n, 6);
    ticks(3);

    // Glitch of DB-1 cycles on ch2.
    in_a[2] = 1'b1;
    ticks(3);
    in_a[2] = 1'b0;
    count_pulses(0, 4, 0, 12, cnt);
    check("glitch_no_event", cnt, 0);
    v = get_vec(0, 0);
    check("glitch_level_ch2", v[2], 0);

    // Bounce then settle high on ch0.
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    r = 0;
    for (int b = 0; b < 5; b++) begin
      in_a[0] = bounce[b];
      tick();
      if (rise_a[0]) r++;
    end
    in_a[0] = 1'b1;
    wait_pulse(0, 1, 0, 20, n, vec, anyv);
    check("bounce_rise_latency", n, 6);
    check("bounce_early_rises", r, 0);
    count_pulses(0, 1, 0, 10, cnt);
    check("bounce_extra_rises", cnt, 0);
    in_a[0] = 1'b0;
    wait_pulse(0, 2, 0, 20, n, vec, anyv);
    check("bounce_fall", n, 6);
    ticks(3);

    // Long press on ch3: 40 cycles held, then a 10-cycle press.
    in_a[3] = 1'b1;
    wait_pulse(0, 1, 3, 20, n, vec, anyv);
    check("long_rise_ch3", n, 6);
    wait_pulse(0, 3, 3, 30, n, vec, anyv);
    check("long_pulse_offset", n, LONG);
    count_pulses(0, 3, 3, 14, cnt);
    check("long_no_repeat", cnt, 0);
    in_a[3] = 1'b0;
    wait_pulse(0, 2, 3, 20, n, vec, anyv);
    check("long_fall_ch3", n, 6);
    in_a[3] = 1'b1;
    ticks(10);
    in_a[3] = 1'b0;
    count_pulses(0, 3, 3, 30, cnt);
    check("short_press_no_long", cnt, 0);

    // Same-cycle press on ch0 and ch3.
    in_a = 4'b1001;
    wait_pulse(0, 1, 0, 20, n, vec, anyv);
    check("multi_rise_latency", n, 6);
    check("multi_rise_vector", vec, 4'b1001);
    check("multi_rise_any", anyv, 1);
    tick();
    check("multi_any_one_cycle", any_a, 0);
    in_a = '0;
    ticks(10);

    // Active-low instance: pull ch1 low.
    in_b[1] = 1'b0;
    wait_pulse(1, 1, 1, 20, n, vec, anyv);
    check("al_rise_ch1", n, 6);
    check("al_rise_vector", vec, 4'b0010);
    check("al_rise_any", anyv, 1);
    in_b = '1;
    wait_pulse(1, 2, 1, 20, n, vec, anyv);
    check("al_fall_ch1", n, 6);
    ticks(3);

    // Random traffic on both instances, with a reset in the middle.
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 9) == 0) in_a[c] = ~in_a[c];
        if ($urandom_range(0, 9) == 0) in_b[c] = ~in_b[c];
      end
      if (cyc == 300) begin
        async_reset();
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event_detect.md
Name: button_event_detect

Overview:
- Multi-channel successor to the single-bit edge detector. It synchronises N raw button/switch inputs, debounces each one and emits per-channel single-cycle events: press (rise), release (fall) and long-press.
- Sits between board push-buttons and the gesture/puzzle control logic.
- Replaces ad-hoc per-button edge detectors with one configurable block.

Parameters:
- N_CH, 4, number of independent input channels (1..32).
- DB_CNT, 500000, debounce length in clk cycles; the synchronised input must differ from the debounced state for this many consecutive cycles before the state changes (min 2).
- LONG_CNT, 100000000, clk cycles of continuous debounced press before long_pulse fires (must exceed DB_CNT).
- ACTIVE_LOW, 0, 1 = raw input is low when pressed; the block inverts it before synchronisation.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset; release is synchronous to clk at the integrator level.
- input_sig  input  N_CH  raw asynchronous button inputs.
- level_o  output  N_CH  debounced pressed state (1 = pressed).
- rise_pulse  output  N_CH  one-cycle pulse on debounced press.
- fall_pulse  output  N_CH  one-cycle pulse on debounced release.
- long_pulse  output  N_CH  one-cycle pulse when a press has lasted LONG_CNT cycles.
- any_event  output  1  registered OR of all rise, fall and long pulses; coincident with them.

Behaviour:
- Reset (rst=0, async): all sync flops, counters, level_o and every pulse output go to 0. Sync flops reset to logical "released" after polarity correction.
- Polarity: p = input_sig XOR {N_CH{ACTIVE_LOW}}, applied before the first flop.
- Synchroniser, per channel: s1<=p; s2<=s1.
- Debounce counter: width $clog2(DB_CNT). Each cycle, per channel:
  - if s2==level_o: cnt<=0.
  - else if cnt==DB_CNT-1: level_o<=s2, cnt<=0; pulse rise (s2=1) or fall (s2=0).
  - else: cnt<=cnt+1.
- Latency: raw input stable before edge 0 gives level_o and pulse updated at edge DB_CNT+1 (DB_CNT+2 edges total). The pulse is high for exactly one cycle.
- Glitch rejection: any excursion shorter than DB_CNT cycles at s2 resets the counter. No state change and no pulse.
- Long press: hold counter width $clog2(LONG_CNT+1) plus a long_done flag per channel.
  - Cleared on the cycle rise_pulse asserts and whenever level_o=0.
  - Increments while level_o=1 and long_done=0.
  - When hold==LONG_CNT-1, long_pulse=1 for one cycle and long_done<=1; the counter stops, with no repeat until release.
  - long_pulse therefore fires at rise_pulse edge + LONG_CNT.
- Release before LONG_CNT: no long_pulse; fall_pulse as normal.
- Channels are fully independent. Simultaneous events on different channels all appear in the same cycle; any_event is a single-cycle OR.
- rise and fall of one channel are mutually exclusive per cycle. long_pulse never coincides with rise_pulse on the same channel.
- Reset mid-operation: all state is lost. A button held through reset release is re-detected as a press after DB_CNT+2 edges, with a fresh rise_pulse; the long-press timing restarts.
- Counters never wrap. The debounce count saturates logically via the compare; the hold count stops at long_done.

Test Plan (N_CH=4, DB_CNT=4, LONG_CNT=20, ACTIVE_LOW=0):
- Reset: assert rst=0 mid-press on ch0 → all outputs 0 immediately (async). Release with input_sig[0]=1 held → rise_pulse[0] 6 edges after reset release.
- Clean press: input_sig[1] 0→1 before edge 0 and held → level_o[1]=1 and rise_pulse[1]=1 after edge 5 only; any_event=1 in the same cycle. Dropping to 0 → fall_pulse[1] 6 edges later.
- Glitch: input_sig[2] high for 3 cycles then low → level_o[2] stays 0; no pulses on any output.
- Bounce: input_sig[0] toggles 1,0,1,1,0,1 then holds 1 → exactly one rise_pulse[0], 6 edges after the final 0→1.
- Long press: hold input_sig[3]=1 for 40 cycles → rise_pulse[3] at edge t, long_pulse[3] at edge t+20 exactly once. Release at 10 cycles instead → no long_pulse.
- Multi-channel/polarity: same-cycle press on ch0 and ch3 → both rise pulses in one cycle, any_event high for one cycle. Rerun with ACTIVE_LOW=1 and input idle at 4'hF, pulling ch1 low → rise_pulse[1] after 6 edges.
